bp_resolve_ctrl: RTL

BP_RESOLVE_CTRL -- requirements
Module: bp_resolve_ctrl

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_inflight_fifo.sv | 59 +++++
 rtl/bp_resolve_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_pkg : shared types and constants for branch-resolution control
// Rev 1.0
// ------------------------------------------------------------------
package bp_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    HOLD    = 2'd2
  } bpState_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bpEntry_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_inflight_fifo : in-order queue of predicted branches awaiting resolution
// Rev 1.0
// ------------------------------------------------------------------
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  bpEntry_t                 pushEntry,
  input  logic                     pop,
  input  logic                     flush,
  output bpEntry_t                 head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] c_ptrOne = 1;
  localparam logic [AW:0]   c_cntOne = 1;

  bpEntry_t      r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;

  // Flush outranks push/pop so a push in the flush cycle is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + c_ptrOne;
      if (pop)  r_rdPtr <= r_rdPtr + c_ptrOne;
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cntOne;
        2'b01:   r_count <= r_count - c_cntOne;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wrPtr] <= pushEntry;
  end

  assign head  = r_mem[r_rdPtr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bp_resolve_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// bp_resolve_ctrl : resolves predicted branches, trains the predictor, recovers on mispredict
// Rev 1.0
// ------------------------------------------------------------------
module bp_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_target,
  input  logic                     push_taken,
  output logic                     push_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     flushD,
  output logic                     flushE,
  output logic                     flushM,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic                     upd_taken,
  output logic                     upd_mis,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
  localparam logic [CW-1:0] c_zero     = '0;
  localparam logic [3:0]    c_holdInit = 4'(HOLD_CYC - 1);

  bpState_t      r_state;
  bpState_t      w_stateNext;
  logic [3:0]    r_holdCnt;
  logic [3:0]    w_holdNext;
  bpEntry_t      w_head;
  bpEntry_t      w_pushEntry;
  logic [CW-1:0] w_count;
  logic          w_run;
  logic          w_pop;
  logic          w_push;
  logic          w_headMis;
  logic          w_mis;
  logic [31:0]   r_redirectPc;
  logic          r_errUnderflow;

  assign w_run       = !rst && (r_state == RUN);
  assign w_pop       = w_run && res_valid && (w_count != c_zero);
  assign w_headMis   = (res_taken != w_head.taken) ||
                       (res_taken && (res_target != w_head.target));
  assign w_mis       = w_pop && w_headMis;
  assign w_push      = push_valid && push_ready;
  assign w_pushEntry = '{pc: push_pc, taken: push_taken, target: push_target};

  bp_inflight_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pushEntry (w_pushEntry),
    .pop       (w_pop),
    .flush     (w_mis),
    .head      (w_head),
    .count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_holdCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_holdCnt <= w_holdNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_holdNext  = r_holdCnt;
    case (r_state)
      RUN: begin
        if (w_mis) w_stateNext = RECOVER;
      end
      RECOVER: begin
        w_stateNext = HOLD;
        w_holdNext  = c_holdInit;
      end
      HOLD: begin
        if (r_holdCnt == 4'd0) w_stateNext = RUN;
        else                   w_holdNext  = r_holdCnt - 4'd1;
      end
      default: w_stateNext = RUN;
    endcase
  end

  always_comb begin
    push_ready     = w_run && ((w_count < c_depth) || w_pop);
    redirect_valid = (r_state == RECOVER);
    flushD         = (r_state == RECOVER);
    flushE         = (r_state == RECOVER);
    flushM         = (r_state == RECOVER);
    upd_valid      = w_pop;
    upd_pc         = w_head.pc;
    upd_taken      = res_taken;
    upd_mis        = w_mis;
  end

  // Correction PC is captured at the mispredict edge and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirectPc   <= '0;
      r_errUnderflow <= 1'b0;
    end else begin
      if (w_mis)
        r_redirectPc <= res_taken ? res_target : (w_head.pc + PC_INC);
      if (w_run && res_valid && (w_count == c_zero))
        r_errUnderflow <= 1'b1;
    end
  end

  assign redirect_pc   = r_redirectPc;
  assign err_underflow = r_errUnderflow;
  assign count         = w_count;

endmodule
`default_nettype wire
